// File: rtl/clock_enables_pkg.sv
// Shared constants, types and divisor helpers for the Lynx clock-enable block.
// Latency: n/a (package only).
// Backpressure: n/a. Optional 8 MHz divisor is compiled in with CLOCK_TURBO_EN.
package clock_enables_pkg;

  // Divisors of the 24 MHz system clock for each CPU speed.
  localparam int DIV_4M   = 6;
  localparam int DIV_6M   = 4;
  localparam int DIV_8M   = 3;

  // Master counter period: one lap is exactly one microsecond at 24 MHz.
  localparam int MCNT_MOD = 24;

  // Counter widths.
  localparam int MCNT_W   = 5;
  localparam int CCNT_W   = 3;

  typedef logic [MCNT_W-1:0] mcnt_t;
  typedef logic [CCNT_W-1:0] ccnt_t;

  // All registered strobes travel together so they share one reset and one edge.
  typedef struct packed {
    logic ce12;
    logic ce1m;
    logic cpu_ne;
    logic cpu_pe;
  } strobes_t;

`ifdef CLOCK_TURBO_EN
  // Turbo wins over speed; otherwise speed picks 6 MHz over the 4 MHz default.
  function automatic ccnt_t div_select(input logic speed, input logic turbo);
    ccnt_t n;
    if (turbo) begin
      n = ccnt_t'(DIV_8M);
    end else if (speed) begin
      n = ccnt_t'(DIV_6M);
    end else begin
      n = ccnt_t'(DIV_4M);
    end
    return n;
  endfunction
`else
  // Only the 4 MHz and 6 MHz divisors exist in this build.
  function automatic ccnt_t div_select(input logic speed);
    ccnt_t n;
    if (speed) begin
      n = ccnt_t'(DIV_6M);
    end else begin
      n = ccnt_t'(DIV_4M);
    end
    return n;
  endfunction
`endif

  // Phase of the CPU counter that produces the negative-edge enable: N/2-1.
  function automatic ccnt_t ne_phase(input ccnt_t n);
    return (n >> 1) - ccnt_t'(1);
  endfunction

  // Last phase of the CPU period, which produces the positive-edge enable.
  function automatic ccnt_t pe_phase(input ccnt_t n);
    return n - ccnt_t'(1);
  endfunction

endpackage

// File: rtl/clock_enables_reset_stretch.sv
// Holds rst_o high for RST_CYCLES clocks after the synchronous reset input falls.
// Latency: rst_o rises on the first edge that samples reset, falls RST_CYCLES edges after reset drops.
// Backpressure: none; a new reset pulse mid-stretch reloads the counter and restarts the full stretch.
module reset_stretch #(
  parameter int RST_CYCLES = 65536
) (
  input  logic clock,
  input  logic reset,
  output logic rst_o
);

  localparam int CNT_W = $clog2(RST_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rst_q;
  logic             rst_d;

  // Count down to zero, then release the stretched reset on the following edge.
  always_comb begin
    cnt_d = cnt_q;
    rst_d = rst_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      rst_d = 1'b0;
    end
  end

  // State register; reset reloads the full stretch and raises rst_o immediately.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= CNT_LOAD;
      rst_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      rst_q <= rst_d;
    end
  end

  assign rst_o = rst_q;

endmodule

// File: rtl/clock_enables.sv
// Derives pixel, 1 MHz and CPU edge enables plus a stretched reset from the 24 MHz clock; turbo via CLOCK_TURBO_EN.
// Latency: every strobe is registered, one cycle after the counter state that decodes it.
// Backpressure: wait_n=0 freezes the CPU counter and gates cpu_ne/cpu_pe; ce12/ce1m/rst_o keep running.
module clock_enables
  import clock_enables_pkg::*;
#(
  parameter int RST_CYCLES = 65536
) (
  input  logic clock,
  input  logic reset,
  input  logic speed,
`ifdef CLOCK_TURBO_EN
  input  logic turbo,
`endif
  input  logic wait_n,
  output logic ce12,
  output logic ce1m,
  output logic cpu_ne,
  output logic cpu_pe,
  output logic rst_o
);

  mcnt_t    mcnt_q;
  mcnt_t    mcnt_d;
  ccnt_t    ccnt_q;
  ccnt_t    ccnt_d;
  ccnt_t    div_q;
  ccnt_t    div_d;
  ccnt_t    div_sel;
  strobes_t stb_q;
  strobes_t stb_d;
  logic     ne_hit;
  logic     pe_hit;
  logic     ccnt_wrap;

  // Divisor requested by the speed inputs; only sampled at a period boundary or in reset.
  always_comb begin
`ifdef CLOCK_TURBO_EN
    div_sel = div_select(speed, turbo);
`else
    div_sel = div_select(speed);
`endif
  end

  // Master counter laps 0..23 every clock regardless of wait_n.
  always_comb begin
    mcnt_d = mcnt_q + mcnt_t'(1);
    if (mcnt_q >= mcnt_t'(MCNT_MOD - 1)) begin
      mcnt_d = '0;
    end
  end

  // CPU phase decode against the divisor held for the current period.
  always_comb begin
    ne_hit    = (ccnt_q == ne_phase(div_q));
    pe_hit    = (ccnt_q == pe_phase(div_q));
    ccnt_wrap = (ccnt_q >= pe_phase(div_q));
  end

  // CPU counter advances only with wait_n; the divisor reloads only on the wrap,
  // so a mid-period speed change always lets the current period finish at full length.
  always_comb begin
    ccnt_d = ccnt_q;
    div_d  = div_q;
    if (wait_n) begin
      if (ccnt_wrap) begin
        ccnt_d = '0;
        div_d  = div_sel;
      end else begin
        ccnt_d = ccnt_q + ccnt_t'(1);
      end
    end
  end

  // Next strobe values; cpu_ne and cpu_pe decode distinct phases so they never coincide.
  always_comb begin
    stb_d        = '0;
    stb_d.ce12   = mcnt_q[0];
    stb_d.ce1m   = (mcnt_q == mcnt_t'(MCNT_MOD - 1));
    stb_d.cpu_ne = wait_n & ne_hit;
    stb_d.cpu_pe = wait_n & pe_hit;
  end

  // Counter and strobe registers; reset clears every strobe on the very next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcnt_q <= '0;
      ccnt_q <= '0;
      div_q  <= div_sel;
      stb_q  <= '0;
    end else begin
      mcnt_q <= mcnt_d;
      ccnt_q <= ccnt_d;
      div_q  <= div_d;
      stb_q  <= stb_d;
    end
  end

  assign ce12   = stb_q.ce12;
  assign ce1m   = stb_q.ce1m;
  assign cpu_ne = stb_q.cpu_ne;
  assign cpu_pe = stb_q.cpu_pe;

  reset_stretch #(
    .RST_CYCLES (RST_CYCLES)
  ) u_reset_stretch (
    .clock (clock),
    .reset (reset),
    .rst_o (rst_o)
  );

endmodule

// File: tb/tb_clock_enables.sv
// Self-checking bench for clock_enables with a short reset stretch; turbo cases build only with CLOCK_TURBO_EN.
// Latency: model predicts each registered strobe one edge after the inputs it depends on.
// Backpressure: wait_n holds are driven directly from the directed sequence.
module tb_clock_enables;

  localparam int RST = 16;

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic speed  = 1'b0;
  logic turbo  = 1'b0;
  logic wait_n = 1'b1;
  logic ce12;
  logic ce1m;
  logic cpu_ne;
  logic cpu_pe;
  logic rst_o;

  int n_checks = 0;
  int n_fail   = 0;

  clock_enables #(
    .RST_CYCLES (RST)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .speed  (speed),
`ifdef CLOCK_TURBO_EN
    .turbo  (turbo),
`endif
    .wait_n (wait_n),
    .ce12   (ce12),
    .ce1m   (ce1m),
    .cpu_ne (cpu_ne),
    .cpu_pe (cpu_pe),
    .rst_o  (rst_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_k: edges since the last sampled reset; m_pos: advances into the current CPU period of length m_n.
  bit m_valid = 1'b0;
  int m_k;
  int m_pos;
  int m_n;
  int m_since;
  bit e_ce12, e_ce1m, e_ne, e_pe, e_rst;

  function automatic int model_div(input logic s, input logic t);
    if (t) return 3;
    if (s) return 4;
    return 6;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_valid = 1'b1;
      m_k     = 0;
      m_pos   = 0;
      m_n     = model_div(speed, turbo);
      m_since = 0;
      e_ce12  = 1'b0;
      e_ce1m  = 1'b0;
      e_ne    = 1'b0;
      e_pe    = 1'b0;
      e_rst   = 1'b1;
    end else if (m_valid) begin
      e_ce12 = ((m_k % 24) % 2) == 1;
      e_ce1m = (m_k % 24) == 23;
      m_k++;
      e_ne = wait_n && (m_pos == m_n / 2 - 1);
      e_pe = wait_n && (m_pos == m_n - 1);
      if (wait_n) begin
        m_pos++;
        if (m_pos == m_n) begin
          m_pos = 0;
          m_n   = model_div(speed, turbo);
        end
      end
      if (m_since < RST) m_since++;
      e_rst = (m_since < RST);
    end
  end

  // Compare every cycle once a reset has been seen.
  always @(negedge clock) begin
    if (m_valid) begin
      check("ce12",   ce12,   e_ce12);
      check("ce1m",   ce1m,   e_ce1m);
      check("cpu_ne", cpu_ne, e_ne);
      check("cpu_pe", cpu_pe, e_pe);
      check("rst_o",  rst_o,  e_rst);
    end
  end

  // ---------------- pulse log for hand-computed expectations ----------------
  int cyc;
  int q12[$];
  int q1m[$];
  int qne[$];
  int qpe[$];
  int rst_hi_last;
  int rst_lo_first;

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic step();
    @(posedge clock);
    #2;
    cyc++;
    if (ce12 === 1'b1)   q12.push_back(cyc);
    if (ce1m === 1'b1)   q1m.push_back(cyc);
    if (cpu_ne === 1'b1) qne.push_back(cyc);
    if (cpu_pe === 1'b1) qpe.push_back(cyc);
    if (rst_o === 1'b1) rst_hi_last = cyc;
    else if (rst_lo_first < 0) rst_lo_first = cyc;
  endtask

  task automatic clear_log();
    cyc = 0;
    q12.delete();
    q1m.delete();
    qne.delete();
    qpe.delete();
    rst_hi_last  = -1;
    rst_lo_first = -1;
  endtask

  // Cycle numbering after this task: cycle k is the state after the k-th edge past the last reset edge.
  task automatic do_reset(input int n);
    reset = 1'b1;
    step();
    check("post_reset_strobes", {28'd0, ce12, ce1m, cpu_ne, cpu_pe}, 32'd0);
    check("post_reset_rst_o", rst_o, 1);
    repeat (n - 1) step();
    reset = 1'b0;
    clear_log();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int bad;
    int mingap;
    int cnt;

    clear_log();

    // --- master strobes over 48 clocks after reset ---
    speed  = 1'b0;
    wait_n = 1'b1;
    do_reset(2);
    repeat (48) step();
    check("t1_ce12_count", q12.size(), 24);
    bad = 0;
    foreach (q12[i]) if (q12[i] != 2 * (i + 1)) bad++;
    check("t1_ce12_alternate", bad, 0);
    check("t1_ce1m_count", q1m.size(), 2);
    check("t1_ce1m_first", qat(q1m, 0), 24);
    check("t1_ce1m_second", qat(q1m, 1), 48);

    // --- 4 MHz CPU enables over 60 clocks ---
    clear_log();
    repeat (60) step();
    check("t2_pe_count", qpe.size(), 10);
    check("t2_ne_count", qne.size(), 10);
    check("t2_pe_first", qat(qpe, 0), 6);
    check("t2_ne_first", qat(qne, 0), 3);
    bad = 0;
    for (int i = 1; i < qpe.size(); i++) if (qpe[i] - qpe[i-1] != 6) bad++;
    for (int i = 0; i < qpe.size(); i++) if (qpe[i] - qat(qne, i) != 3) bad++;
    check("t2_period_and_ne_lead", bad, 0);

    // --- speed 0 -> 1 at ccnt=2 of the second period ---
    speed = 1'b0;
    do_reset(1);
    repeat (8) step();
    speed = 1'b1;
    repeat (14) step();
    check("t3_pe_count", qpe.size(), 4);
    check("t3_pe0", qat(qpe, 0), 6);
    check("t3_pe1", qat(qpe, 1), 12);
    check("t3_pe2", qat(qpe, 2), 16);
    check("t3_pe3", qat(qpe, 3), 20);
    check("t3_ne_count", qne.size(), 5);
    mingap = 1000;
    for (int i = 1; i < qpe.size(); i++) if (qpe[i] - qpe[i-1] < mingap) mingap = qpe[i] - qpe[i-1];
    check("t3_min_gap_ge4", (mingap >= 4) ? 1 : 0, 1);

    // --- wait_n low for 7 clocks starting at ccnt=4 (mid-operation reset first) ---
    speed = 1'b0;
    do_reset(1);
    repeat (4) step();
    wait_n = 1'b0;
    repeat (7) step();
    wait_n = 1'b1;
    repeat (10) step();
    check("t4_pe_count", qpe.size(), 2);
    check("t4_pe0", qat(qpe, 0), 13);
    check("t4_pe1", qat(qpe, 1), 19);
    check("t4_ne_count", qne.size(), 2);
    check("t4_ne0", qat(qne, 0), 3);
    check("t4_ne1", qat(qne, 1), 16);
    cnt = 0;
    foreach (q12[i]) if (q12[i] >= 5 && q12[i] <= 11) cnt++;
    check("t4_ce12_during_hold", cnt, 3);

    // --- reset stretch with a 3-clock reset pulse ---
    do_reset(3);
    repeat (20) step();
    check("t5_rst_last_high", rst_hi_last, 15);
    check("t5_rst_first_low", rst_lo_first, 16);
    check("t5_ce12_during_stretch", (qat(q12, 0) > 0 && qat(q12, 0) < 16) ? 1 : 0, 1);

    // --- re-pulse reset when the stretch count is 5 ---
    do_reset(3);
    repeat (10) step();
    reset = 1'b1;
    step();
    check("t6_repulse_strobes", {28'd0, ce12, ce1m, cpu_ne, cpu_pe}, 32'd0);
    reset = 1'b0;
    repeat (20) step();
    check("t6_rst_last_high", rst_hi_last, 26);
    check("t6_rst_first_low", rst_lo_first, 27);

`ifdef CLOCK_TURBO_EN
    // --- 8 MHz turbo divisor ---
    turbo = 1'b1;
    do_reset(1);
    repeat (12) step();
    check("t7_pe_count", qpe.size(), 4);
    check("t7_pe0", qat(qpe, 0), 3);
    check("t7_pe3", qat(qpe, 3), 12);
    check("t7_ne0", qat(qne, 0), 1);
    check("t7_ne3", qat(qne, 3), 10);
    turbo = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
